// File: rtl/fetch_unit_if.sv
// fetch_unit_if: req/ack instruction-memory bus between the fetch stage and memory.
`default_nettype none

interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage (IDLE -> REQ -> ISSUE), next-PC
// selection from jump/branch/zero of the issued instruction.
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [5:0]  BUBBLE_OP = 6'b111111
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master imem,
   input  logic         stall,
   input  logic         jump,
   input  logic         branch,
   input  logic         zero,
   output logic         valid,
   output logic [31:0]  instr,
   output logic [5:0]   opcode,
   output logic [31:0]  pc_out,
   output logic [31:0]  pc_plus4
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] next_pc;
   logic [31:0] br_offset;

   assign pc_plus4  = pc_q + 32'd4;
   assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // Jump outranks a taken branch when the control unit asserts both.
   always_comb begin
      if (jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (branch && zero) begin
         next_pc = pc_plus4 + br_offset;
      end else begin
         next_pc = pc_plus4;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem.ack) begin
               instr_d = imem.data;
               valid_d = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!stall) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               state_d = ST_REQ;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign imem.req  = (state_q == ST_REQ);
   assign imem.addr = pc_q;
   assign valid     = valid_q;
   assign instr     = instr_q;
   assign opcode    = valid_q ? instr_q[31:26] : BUBBLE_OP;
   assign pc_out    = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (addresses and issued words queued at stimulus time).
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, jump, branch, zero;
   logic        valid;
   logic [31:0] instr, pc_out, pc_plus4;
   logic [5:0]  opcode;

   logic        w_valid;
   logic [31:0] w_instr, w_pc_out, w_pc_plus4;
   logic [5:0]  w_opcode;

   fetch_unit_if imem_if ();
   fetch_unit_if wrap_if ();

   fetch_unit u_dut (
      .clk      (clk),
      .rst      (rst),
      .imem     (imem_if),
      .stall    (stall),
      .jump     (jump),
      .branch   (branch),
      .zero     (zero),
      .valid    (valid),
      .instr    (instr),
      .opcode   (opcode),
      .pc_out   (pc_out),
      .pc_plus4 (pc_plus4)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk      (clk),
      .rst      (rst),
      .imem     (wrap_if),
      .stall    (1'b0),
      .jump     (1'b0),
      .branch   (1'b0),
      .zero     (1'b0),
      .valid    (w_valid),
      .instr    (w_instr),
      .opcode   (w_opcode),
      .pc_out   (w_pc_out),
      .pc_plus4 (w_pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } issue_t;

   issue_t      sb_q[$];
   logic [31:0] addr_q[$];
   issue_t      cur;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Serve one fetch: wait for req, hold ack low for 'waits' cycles, then return 'data'.
   task automatic fetch(input int waits, input logic [31:0] data);
      logic [31:0] exp_a;
      bit          seen;
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         if (imem_if.req) seen = 1'b1;
         else step();
      end
      if (!seen) begin
         check("req_timeout", 32'd0, 32'd1);
         return;
      end
      if (addr_q.size() == 0) begin
         check("addr_sb_empty", 32'd0, 32'd1);
         return;
      end
      exp_a = addr_q.pop_front();
      check("imem_addr", imem_if.addr, exp_a);
      for (int w = 0; w < waits; w++) begin
         imem_if.ack = 1'b0;
         step();
         check("wait_req", 32'(imem_if.req), 32'd1);
         check("wait_addr", imem_if.addr, exp_a);
         check("wait_valid", 32'(valid), 32'd0);
         check("wait_opcode", 32'(opcode), 32'h3F);
      end
      imem_if.ack  = 1'b1;
      imem_if.data = data;
      sb_q.push_back('{pc: exp_a, ins: data});
      step();
      imem_if.ack  = 1'b0;
      imem_if.data = $urandom;
      cur = sb_q.pop_front();
      check("issue_valid", 32'(valid), 32'd1);
      check("issue_req", 32'(imem_if.req), 32'd0);
      check("instr", instr, cur.ins);
      check("opcode", 32'(opcode), 32'(cur.ins[31:26]));
      check("pc_out", pc_out, cur.pc);
   endtask

   // Hold the issued instruction for 'stalls' cycles (noise on jump/branch/zero and a
   // spurious ack), then release with the given control outcome.
   task automatic issue(input int stalls, input logic j, input logic b, input logic z,
                        input logic [31:0] exp_next);
      for (int s = 0; s < stalls; s++) begin
         stall        = 1'b1;
         jump         = 1'($urandom_range(1));
         branch       = 1'($urandom_range(1));
         zero         = 1'($urandom_range(1));
         imem_if.ack  = 1'b1;
         imem_if.data = $urandom;
         step();
         check("stall_instr", instr, cur.ins);
         check("stall_pc", pc_out, cur.pc);
         check("stall_valid", 32'(valid), 32'd1);
         check("stall_req", 32'(imem_if.req), 32'd0);
      end
      imem_if.ack = 1'b0;
      stall       = 1'b0;
      jump        = j;
      branch      = b;
      zero        = z;
      addr_q.push_back(exp_next);
      step();
      jump   = 1'b0;
      branch = 1'b0;
      zero   = 1'b0;
      check("redir_valid", 32'(valid), 32'd0);
      check("redir_opcode", 32'(opcode), 32'h3F);
      check("redir_req", 32'(imem_if.req), 32'd1);
   endtask

   initial begin
      rst          = 1'b1;
      stall        = 1'b0;
      jump         = 1'b0;
      branch       = 1'b0;
      zero         = 1'b0;
      imem_if.ack  = 1'b0;
      imem_if.data = 32'd0;
      wrap_if.ack  = 1'b0;
      wrap_if.data = 32'd0;

      repeat (3) step();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_opcode", 32'(opcode), 32'h3F);
      check("rst_req", 32'(imem_if.req), 32'd0);
      check("rst_pc", pc_out, 32'd0);
      check("rst_addr", imem_if.addr, 32'd0);
      check("rst_pc4", pc_plus4, 32'd4);
      check("rst_instr", instr, 32'd0);
      check("wrap_pc", w_pc_out, 32'hFFFF_FFFC);
      check("wrap_pc4", w_pc_plus4, 32'd0);

      rst = 1'b0;
      check("idle_req", 32'(imem_if.req), 32'd0);
      step();
      check("first_req", 32'(imem_if.req), 32'd1);
      check("first_addr", imem_if.addr, 32'd0);
      addr_q.push_back(32'd0);

      fetch(0, 32'h2008_0005);  issue(0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
      fetch(3, 32'h0800_0004);  issue(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
      fetch(1, 32'h1000_FFFC);  issue(2, 1'b0, 1'b1, 1'b1, 32'h0000_0004);
      fetch(0, 32'h0800_0004);  issue(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
      fetch(0, 32'h1000_FFFC);  issue(0, 1'b0, 1'b1, 1'b0, 32'h0000_0014);
      fetch(2, 32'h0810_0002);  issue(0, 1'b1, 1'b0, 1'b0, 32'h0040_0008);
      fetch(0, 32'h0810_0010);  issue(4, 1'b1, 1'b1, 1'b1, 32'h0040_0040);

      // Reset while a fetch of 0x0040_0040 is outstanding; its ack lands in IDLE.
      step();
      rst = 1'b1;
      #1;
      check("abort_req", 32'(imem_if.req), 32'd0);
      check("abort_pc", pc_out, 32'd0);
      check("abort_valid", 32'(valid), 32'd0);
      step();
      rst          = 1'b0;
      imem_if.ack  = 1'b1;
      imem_if.data = 32'hDEAD_BEEF;
      step();
      imem_if.ack = 1'b0;
      check("late_valid", 32'(valid), 32'd0);
      check("late_req", 32'(imem_if.req), 32'd1);
      check("late_instr", instr, 32'd0);
      check("late_addr", imem_if.addr, 32'd0);
      addr_q.delete();
      addr_q.push_back(32'd0);
      fetch(0, 32'h3C01_0000);  issue(0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the control unit. It owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and holds the fetched instruction for decode. It presents the opcode field to the control unit, then computes the next PC from the unit's `jump` and `branch` outputs and the ALU `zero` flag.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `BUBBLE_OP`, default `6'b111111`: opcode driven while no instruction is valid. It must decode to the control unit's default case, so that `en=0`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  byte address of the fetch; equals `pc_out`.
- `imem_ack`  in  1  memory response valid; `imem_data` is sampled on the same edge.
- `imem_data`  in  32  instruction word.
- `stall`  in  1  downstream hold; freezes the issued instruction.
- `jump`  in  1  from the control unit, for the issued instruction.
- `branch`  in  1  from the control unit, for the issued instruction.
- `zero`  in  1  ALU branch condition; 1 means taken, for both BEQ and BNE.
- `valid`  out  1  `instr`/`opcode` hold a live instruction.
- `instr`  out  32  fetched instruction register.
- `opcode`  out  6  `valid ? instr[31:26] : BUBBLE_OP`.
- `pc_out`  out  32  PC of the current or in-flight instruction.
- `pc_plus4`  out  32  `pc_out + 4`, modulo 2^32.

## Operation
- States: IDLE, REQ, ISSUE.
- IDLE: entered only from reset. It moves to REQ unconditionally on the next edge.
- REQ: `imem_req=1` and `imem_addr=pc_out`, both held stable until ack.
  - Edge with `imem_ack=1`: `instr <= imem_data`, `valid <= 1`, go to ISSUE.
  - Otherwise remain in REQ.
- ISSUE: `imem_req=0`, `valid=1`.
  - `stall=1`: hold PC, `instr` and state.
  - `stall=0`: `pc <= next_pc`, `valid <= 0`, go to REQ.
- next_pc priority (evaluated combinationally in ISSUE):
  1. `jump=1`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  2. Else `branch & zero`: `pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})`, modulo 2^32.
  3. Else `pc_plus4`.
- `jump` wins over a simultaneous `branch & zero`.
- `imem_ack` is ignored in IDLE and ISSUE. A spurious ack causes no state change.
- `instr` keeps its last value after `valid` drops, but `opcode` shows `BUBBLE_OP` whenever `valid=0`.

## Timing
- Reset values, applied asynchronously while `rst=1`:
  - state=IDLE, `pc_out=RESET_PC`, `pc_plus4=RESET_PC+4`.
  - `instr=0`, `valid=0`, `opcode=BUBBLE_OP`, `imem_req=0`, `imem_addr=RESET_PC`.
- First `imem_req=1` occurs in the second cycle after `rst` deasserts: one IDLE cycle, then REQ.
- Zero-wait memory (ack in the first REQ cycle): `valid=1` in the following cycle.
- Minimum throughput: one instruction per 2 cycles (REQ, ISSUE).
- N wait cycles add N cycles of REQ. `imem_addr` must not change during them.
- `jump`, `branch` and `zero` are sampled only on the ISSUE edge where `stall=0`. Their values during stall cycles or in other states have no effect.
- Redirect takes effect on the very next REQ. No wrong-path fetch is ever issued.
- Reset mid-operation (any state, including a REQ with ack due) aborts immediately. After release, fetch restarts from `RESET_PC`, and a late ack arriving in IDLE is dropped.
- PC wrap: `32'hFFFF_FFFC + 4 = 0`. No exception is raised.

## Test plan
- Reset: hold `rst` 3 cycles → `valid=0`, `opcode=6'h3F`, `imem_req=0`, `pc_out=0`. Release → `imem_req=1`, `imem_addr=0` in the 2nd cycle after release.
- Zero-wait sequential fetch: ack immediately with `32'h2008_0005`.
  - Next cycle: `valid=1`, `opcode=6'b001000`.
  - With `stall=0`, no jump or branch: next request at `imem_addr=4`.
- Wait states: hold ack low 3 cycles → `imem_req=1` and `imem_addr` stable for 4 cycles, `valid=0`, `opcode=6'h3F`.
- Branch at `pc=0x10`, `instr=32'h1000_FFFC`:
  - `branch=1`, `zero=1` → next `imem_addr=0x04`.
  - Repeat with `zero=0` → `0x14`.
- Jump at `pc=0x0040_0008`, `instr=32'h0810_0010`, with `jump=1`, `branch=1`, `zero=1` → next `imem_addr=0x0040_0040` (jump priority).
- Stall and reset:
  - `stall=1` for 4 cycles in ISSUE → `instr`, `pc_out` and `valid` unchanged, no `imem_req`.
  - Assert `rst` in REQ one cycle before ack, release → fetch restarts at `RESET_PC`. The late ack is ignored.
